// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Iteration counter width: enough to count 0..width-1, never narrower than one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/mult_abs_sign.sv
// Operand magnitude and result-sign extraction for the shift-add multiplier.
// Kept apart so the sign path can be approximated independently of the datapath.
module mult_abs_sign #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic [WIDTH-1:0] a_mag,
    output logic [WIDTH-1:0] b_mag,
    output logic             neg
);

    // Magnitudes in signed mode (the most negative value maps onto 2^(WIDTH-1)), pass-through otherwise.
    always_comb begin
        a_mag = a;
        b_mag = b;
        neg   = 1'b0;
        if (is_signed) begin
            if (a[WIDTH-1]) begin
                a_mag = -a;
            end else begin
                a_mag = a;
            end
            if (b[WIDTH-1]) begin
                b_mag = -b;
            end else begin
                b_mag = b;
            end
            neg = a[WIDTH-1] ^ b[WIDTH-1];
        end else begin
            a_mag = a;
            b_mag = b;
            neg   = 1'b0;
        end
    end

endmodule

// File: rtl/mult_seq_shift_add.sv
// Iterative radix-2 shift-add multiplier with valid/ready handshakes on both sides.
// One operation in flight; fixed latency of WIDTH cycles from acceptance to result.
module mult_seq_shift_add
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] o
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    mult_state_t       state_r;
    mult_state_t       state_next_s;
    logic [PW-1:0]     mcand_r;
    logic [WIDTH-1:0]  mplier_r;
    logic [PW-1:0]     acc_r;
    logic [CW-1:0]     cnt_r;
    logic              neg_r;
    logic [PW-1:0]     o_r;
    logic              out_valid_r;
    logic              in_ready_r;

    logic [WIDTH-1:0]  a_mag_s;
    logic [WIDTH-1:0]  b_mag_s;
    logic              neg_s;
    logic              accept_s;
    logic              out_hs_s;
    logic              last_s;
    logic [PW-1:0]     acc_next_s;
    logic [PW-1:0]     prod_s;

    mult_abs_sign #(
        .WIDTH (WIDTH)
    ) u_abs_sign (
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .a_mag     (a_mag_s),
        .b_mag     (b_mag_s),
        .neg       (neg_s)
    );

    // Handshake qualifiers, one accumulation step and the sign-corrected final product.
    always_comb begin
        accept_s   = in_valid & in_ready_r;
        out_hs_s   = out_valid_r & out_ready;
        last_s     = (cnt_r == CNT_LAST);
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
        if (neg_r) begin
            prod_s = -acc_next_s;
        end else begin
            prod_s = acc_next_s;
        end
    end

    // Next-state logic: accept in IDLE, iterate exactly WIDTH times, hold result until taken.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (out_hs_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r     <= '0;
            mplier_r    <= '0;
            acc_r       <= '0;
            cnt_r       <= '0;
            neg_r       <= 1'b0;
            o_r         <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        mcand_r    <= {{WIDTH{1'b0}}, a_mag_s};
                        mplier_r   <= b_mag_s;
                        neg_r      <= neg_s;
                        acc_r      <= '0;
                        cnt_r      <= '0;
                        in_ready_r <= 1'b0;
                    end
                end
                RUN: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CW'(1);
                    if (last_s) begin
                        o_r         <= prod_s;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_hs_s) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign o         = o_r;

endmodule
